// File: rtl/clk_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : clk_set_ctrl
//  Brief  : Time-set sequencer for the RTC core. Turns the debounced
//           mode/up/down buttons into a minutes/seconds edit session with
//           auto-repeat and idle timeout, then writes both fields to the
//           clock core as two back-to-back single-cycle loads.
//  Rev    : 1.0  initial release
// ============================================================================
module clk_set_ctrl #(
  parameter int MAX_VAL     = 59,
  parameter int REPEAT_DLY  = 50000000,
  parameter int REPEAT_PER  = 10000000,
  parameter int TIMEOUT_CYC = 1000000000,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] cur_seconds,
  input  logic [5:0] cur_minutes,
  output logic       load,
  output logic [1:0] addrs,
  output logic [5:0] data_in,
  output logic       set_active,
  output logic [1:0] edit_field,
  output logic [5:0] edit_value
);

  localparam logic [1:0]       FIELD_SEC  = 2'b00;
  localparam logic [1:0]       FIELD_MIN  = 2'b01;
  localparam logic [5:0]       MAX_C      = 6'(MAX_VAL);
  // The repeat counter fires one cycle before it would reach REPEAT_DLY and
  // reloads so that the next fire lands exactly REPEAT_PER cycles later.
  localparam logic [CNT_W-1:0] RPT_FIRE   = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DLY - REPEAT_PER);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EDIT_MIN   = 3'd1,
    EDIT_SEC   = 3'd2,
    COMMIT_MIN = 3'd3,
    COMMIT_SEC = 3'd4
  } state_t;

  state_t           state;
  logic             mode_q, up_q, down_q;
  logic [5:0]       edit_min, edit_sec;
  logic [CNT_W-1:0] rpt_cnt, tmo_cnt;

  function automatic logic [5:0] val_inc(input logic [5:0] v);
    return (v == MAX_C) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] val_dec(input logic [5:0] v);
    return (v == 6'd0) ? MAX_C : v - 6'd1;
  endfunction

  logic in_edit, mode_edge, up_edge, down_edge, held_one, any_btn;
  logic rpt_fire, step_up, step_dn, timeout_hit;

  assign in_edit     = (state == EDIT_MIN) || (state == EDIT_SEC);
  assign mode_edge   = btn_mode & ~mode_q;
  assign up_edge     = btn_up & ~up_q;
  assign down_edge   = btn_down & ~down_q;
  assign held_one    = btn_up ^ btn_down;
  assign any_btn     = btn_mode | btn_up | btn_down;
  assign rpt_fire    = held_one && (rpt_cnt == RPT_FIRE);
  // A mode edge changes state instead of stepping; up+down together never step.
  assign step_up     = in_edit & ~mode_edge & btn_up & ~btn_down & (up_edge | rpt_fire);
  assign step_dn     = in_edit & ~mode_edge & btn_down & ~btn_up & (down_edge | rpt_fire);
  assign timeout_hit = in_edit & ~any_btn & (tmo_cnt == TMO_LAST);

  // Button history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      mode_q <= btn_mode;
      up_q   <= btn_up;
      down_q <= btn_down;
    end
  end

  // Auto-repeat counter: runs only while exactly one of up/down is held.
  always_ff @(posedge clk) begin
    if (reset || !in_edit || mode_edge || !held_one || up_edge || down_edge)
      rpt_cnt <= '0;
    else if (rpt_fire)
      rpt_cnt <= RPT_RELOAD;
    else
      rpt_cnt <= rpt_cnt + 1'b1;
  end

  // Idle timeout counter: any pressed button keeps the session alive.
  always_ff @(posedge clk) begin
    if (reset || !in_edit || any_btn || timeout_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Session FSM; outputs are registered for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      edit_min   <= 6'd0;
      edit_sec   <= 6'd0;
      load       <= 1'b0;
      addrs      <= 2'b00;
      data_in    <= 6'd0;
      set_active <= 1'b0;
      edit_field <= 2'b00;
      edit_value <= 6'd0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_edge) begin
            state      <= EDIT_MIN;
            edit_min   <= cur_minutes;
            edit_sec   <= cur_seconds;
            set_active <= 1'b1;
            edit_field <= FIELD_MIN;
            edit_value <= cur_minutes;
          end
        end
        EDIT_MIN: begin
          if (timeout_hit) begin
            state      <= IDLE;
            set_active <= 1'b0;
            edit_field <= 2'b00;
            edit_value <= 6'd0;
          end else if (mode_edge) begin
            state      <= EDIT_SEC;
            edit_field <= FIELD_SEC;
            edit_value <= edit_sec;
          end else if (step_up) begin
            edit_min   <= val_inc(edit_min);
            edit_value <= val_inc(edit_min);
          end else if (step_dn) begin
            edit_min   <= val_dec(edit_min);
            edit_value <= val_dec(edit_min);
          end
        end
        EDIT_SEC: begin
          if (timeout_hit) begin
            state      <= IDLE;
            set_active <= 1'b0;
            edit_field <= 2'b00;
            edit_value <= 6'd0;
          end else if (mode_edge) begin
            state      <= COMMIT_MIN;
            load       <= 1'b1;
            addrs      <= FIELD_MIN;
            data_in    <= edit_min;
            set_active <= 1'b0;
            edit_field <= 2'b00;
            edit_value <= 6'd0;
          end else if (step_up) begin
            edit_sec   <= val_inc(edit_sec);
            edit_value <= val_inc(edit_sec);
          end else if (step_dn) begin
            edit_sec   <= val_dec(edit_sec);
            edit_value <= val_dec(edit_sec);
          end
        end
        COMMIT_MIN: begin
          state   <= COMMIT_SEC;
          load    <= 1'b1;
          addrs   <= FIELD_SEC;
          data_in <= edit_sec;
        end
        COMMIT_SEC: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_clk_set_ctrl
//  Brief  : Self-checking bench for clk_set_ctrl with a modular-arithmetic
//           reference model and a load-pulse log.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_clk_set_ctrl;
  localparam int MAXV = 59;
  localparam int DLY  = 8;
  localparam int PER  = 4;
  localparam int TMO  = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [5:0] cur_seconds = 6'd0, cur_minutes = 6'd0;
  logic       load, set_active;
  logic [1:0] addrs, edit_field;
  logic [5:0] data_in, edit_value;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [1:0] log_a[$];
  logic [5:0] log_d[$];
  int         log_c[$];

  clk_set_ctrl #(.MAX_VAL(MAXV), .REPEAT_DLY(DLY), .REPEAT_PER(PER),
                 .TIMEOUT_CYC(TMO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .cur_seconds(cur_seconds), .cur_minutes(cur_minutes),
    .load(load), .addrs(addrs), .data_in(data_in), .set_active(set_active),
    .edit_field(edit_field), .edit_value(edit_value));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with load high is logged with its field, value and cycle.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      log_a.push_back(addrs);
      log_d.push_back(data_in);
      log_c.push_back(cyc);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_c.delete();
  endtask

  // Drive a button combination for n sampled cycles, then release for one.
  task automatic press(input logic m, input logic u, input logic d, input int n = 1);
    btn_mode = m; btn_up = u; btn_down = d;
    tick(n);
    btn_mode = 0; btn_up = 0; btn_down = 0;
    tick(1);
  endtask

  function automatic int wrap(input int v);
    return ((v % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
  endfunction

  // Steps produced by holding one button for h sampled cycles.
  function automatic int rep_steps(input int h);
    return 1 + ((h - 1 >= DLY) ? ((h - 1 - DLY) / PER + 1) : 0);
  endfunction

  task automatic test_reset();
    reset = 1;
    tick(10);
    n_checks++; if (load !== 1'b0) begin n_errors++; $display("FAIL reset_load: got %b expected 0", load); end
    n_checks++; if (addrs !== 2'b00) begin n_errors++; $display("FAIL reset_addrs: got %b expected 00", addrs); end
    n_checks++; if (data_in !== 6'd0) begin n_errors++; $display("FAIL reset_data: got %0d expected 0", data_in); end
    n_checks++; if (set_active !== 1'b0) begin n_errors++; $display("FAIL reset_active: got %b expected 0", set_active); end
    n_checks++; if (edit_field !== 2'b00) begin n_errors++; $display("FAIL reset_field: got %b expected 00", edit_field); end
    n_checks++; if (edit_value !== 6'd0) begin n_errors++; $display("FAIL reset_value: got %0d expected 0", edit_value); end
    reset = 0;
    tick(2);
    clear_log();
    press(0, 1, 0);
    press(0, 0, 1);
    tick(2);
    n_checks++; if (set_active !== 1'b0) begin n_errors++; $display("FAIL idle_up_active: got %b expected 0", set_active); end
    n_checks++; if (log_a.size() != 0) begin n_errors++; $display("FAIL idle_up_load: got %0d loads expected 0", log_a.size()); end
  endtask

  // Full session with single presses; checks display and the two loads.
  task automatic run_session(input int cm, input int cs, input int um, input int dm,
                             input int us, input int ds);
    int exp_m, exp_s, t0;
    exp_m = wrap(cm + um - dm);
    exp_s = wrap(cs + us - ds);
    cur_minutes = 6'(cm); cur_seconds = 6'(cs);
    clear_log();
    press(1, 0, 0);
    n_checks++; if (set_active !== 1'b1 || edit_field !== 2'b01 || edit_value !== 6'(cm)) begin
      n_errors++; $display("FAIL enter_min: got act=%b fld=%b val=%0d expected 1 01 %0d", set_active, edit_field, edit_value, cm); end
    for (int i = 0; i < um; i++) press(0, 1, 0);
    for (int i = 0; i < dm; i++) press(0, 0, 1);
    n_checks++; if (edit_value !== 6'(exp_m)) begin n_errors++; $display("FAIL edit_min: got %0d expected %0d", edit_value, exp_m); end
    press(1, 0, 0);
    n_checks++; if (edit_field !== 2'b00 || edit_value !== 6'(cs)) begin
      n_errors++; $display("FAIL enter_sec: got fld=%b val=%0d expected 00 %0d", edit_field, edit_value, cs); end
    for (int i = 0; i < ds; i++) press(0, 0, 1);
    for (int i = 0; i < us; i++) press(0, 1, 0);
    n_checks++; if (edit_value !== 6'(exp_s)) begin n_errors++; $display("FAIL edit_sec: got %0d expected %0d", edit_value, exp_s); end
    btn_mode = 1;
    tick(1);
    t0 = cyc;
    btn_mode = 0;
    tick(4);
    n_checks++; if (log_a.size() != 2) begin n_errors++; $display("FAIL commit_count: got %0d loads expected 2", log_a.size()); end
    else begin
      n_checks++; if (log_a[0] !== 2'b01 || log_d[0] !== 6'(exp_m)) begin
        n_errors++; $display("FAIL commit_min: got addrs=%b data=%0d expected 01 %0d", log_a[0], log_d[0], exp_m); end
      n_checks++; if (log_a[1] !== 2'b00 || log_d[1] !== 6'(exp_s)) begin
        n_errors++; $display("FAIL commit_sec: got addrs=%b data=%0d expected 00 %0d", log_a[1], log_d[1], exp_s); end
      n_checks++; if (log_c[0] != t0 || log_c[1] != t0 + 1) begin
        n_errors++; $display("FAIL commit_timing: got cycles %0d,%0d expected %0d,%0d", log_c[0], log_c[1], t0, t0 + 1); end
    end
    n_checks++; if (set_active !== 1'b0 || load !== 1'b0) begin
      n_errors++; $display("FAIL commit_idle: got act=%b load=%b expected 0 0", set_active, load); end
  endtask

  task automatic test_commit();
    run_session(12, 34, 3, 0, 0, 2);
    for (int k = 0; k < 4; k++)
      run_session($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_wrap();
    cur_minutes = 6'd59; cur_seconds = 6'd0;
    clear_log();
    press(1, 0, 0);
    press(0, 1, 0);
    n_checks++; if (edit_value !== 6'd0) begin n_errors++; $display("FAIL wrap_up: got %0d expected 0", edit_value); end
    press(1, 0, 0);
    press(0, 0, 1);
    n_checks++; if (edit_value !== 6'd59) begin n_errors++; $display("FAIL wrap_down: got %0d expected 59", edit_value); end
    press(0, 1, 1, 3);
    n_checks++; if (edit_value !== 6'd59) begin n_errors++; $display("FAIL up_down_both: got %0d expected 59", edit_value); end
    press(1, 0, 0);
    tick(3);
    n_checks++; if (log_a.size() != 2 || log_d[0] !== 6'd0 || log_d[1] !== 6'd59) begin
      n_errors++; $display("FAIL wrap_commit: got %0d loads expected 2 with data 0,59", log_a.size()); end
  endtask

  task automatic hold_check(input int start, input logic up, input int h);
    int exp;
    exp = wrap(start + (up ? rep_steps(h) : -rep_steps(h)));
    cur_minutes = 6'(start);
    press(1, 0, 0);
    press(0, up, ~up, h);
    n_checks++; if (edit_value !== 6'(exp)) begin
      n_errors++; $display("FAIL repeat start=%0d up=%b hold=%0d: got %0d expected %0d", start, up, h, edit_value, exp); end
    press(1, 0, 0);
    press(1, 0, 0);
    tick(3);
    clear_log();
  endtask

  task automatic test_repeat();
    hold_check(10, 1'b1, 21);
    for (int k = 0; k < 6; k++)
      hold_check($urandom_range(0, MAXV), 1'($urandom_range(0, 1)), $urandom_range(1, 26));
  endtask

  task automatic test_timeout();
    clear_log();
    cur_minutes = 6'd7;
    press(1, 0, 0);
    tick(TMO - 10);
    n_checks++; if (set_active !== 1'b1) begin n_errors++; $display("FAIL timeout_early: got %b expected 1", set_active); end
    tick(15);
    n_checks++; if (set_active !== 1'b0 || edit_field !== 2'b00 || edit_value !== 6'd0) begin
      n_errors++; $display("FAIL timeout_abort: got act=%b fld=%b val=%0d expected 0 00 0", set_active, edit_field, edit_value); end
    n_checks++; if (log_a.size() != 0) begin n_errors++; $display("FAIL timeout_load: got %0d loads expected 0", log_a.size()); end
  endtask

  // Reset lands on the edge that would move the FSM into its seconds load.
  task automatic test_reset_commit();
    cur_minutes = 6'd20; cur_seconds = 6'd40;
    clear_log();
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    btn_mode = 1;
    tick(1);
    btn_mode = 0;
    reset = 1;
    tick(1);
    n_checks++; if (load !== 1'b0 || set_active !== 1'b0) begin
      n_errors++; $display("FAIL reset_commit_now: got load=%b act=%b expected 0 0", load, set_active); end
    reset = 0;
    tick(4);
    n_checks++; if (log_a.size() != 1) begin n_errors++; $display("FAIL reset_commit_count: got %0d loads expected 1", log_a.size()); end
    else begin
      n_checks++; if (log_a[0] !== 2'b01 || log_d[0] !== 6'd21) begin
        n_errors++; $display("FAIL reset_commit_min: got addrs=%b data=%0d expected 01 21", log_a[0], log_d[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_wrap();
    test_repeat();
    test_timeout();
    test_reset_commit();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
